// File: rtl/fll_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fll_cfg_arbiter
// Description : Two-requester round-robin arbiter in front of a single FLL
//               configuration bus. One transaction in flight at a time, with
//               an ack timeout that completes the access with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fll_cfg_arbiter #(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // requester side (index 0 = boot/debug, 1 = SoC register port)
  input  logic [1:0]            s_req_i,
  input  logic [2*ADDR_W-1:0]   s_addr_i,
  input  logic [2*DATA_W-1:0]   s_wdata_i,
  input  logic [1:0]            s_web_i,
  output logic [1:0]            s_ack_o,
  output logic [DATA_W-1:0]     s_rdata_o,
  output logic                  s_err_o,
  // FLL config bus master side
  output logic                  fll_req_o,
  output logic [ADDR_W-1:0]     fll_addr_o,
  output logic [DATA_W-1:0]     fll_wdata_o,
  output logic                  fll_web_o,
  input  logic                  fll_ack_i,
  input  logic [DATA_W-1:0]     fll_rdata_i,
  // status
  output logic                  busy_o,
  output logic                  grant_o
);

  // 16 bits covers the largest legal timeout (65535 -> last count 65534)
  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               prio, prio_nxt;      // port that wins a simultaneous request
  logic               win;
  logic [1:0]         s_ack_nxt;
  logic [DATA_W-1:0]  s_rdata_nxt;
  logic               s_err_nxt;
  logic               fll_req_nxt;
  logic [ADDR_W-1:0]  fll_addr_nxt;
  logic [DATA_W-1:0]  fll_wdata_nxt;
  logic               fll_web_nxt;
  logic               busy_nxt;
  logic               grant_nxt;

  // Round-robin pick: contention goes to the priority port, otherwise the sole requester
  always_comb begin
    win = (s_req_i == 2'b11) ? prio : s_req_i[1];
  end

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    prio_nxt      = prio;
    s_ack_nxt     = 2'b00;
    s_rdata_nxt   = s_rdata_o;
    s_err_nxt     = s_err_o;
    fll_req_nxt   = fll_req_o;
    fll_addr_nxt  = fll_addr_o;
    fll_wdata_nxt = fll_wdata_o;
    fll_web_nxt   = fll_web_o;
    busy_nxt      = busy_o;
    grant_nxt     = grant_o;

    case (state)
      IDLE: begin
        // fll_ack_i is deliberately not looked at here
        if (|s_req_i) begin
          grant_nxt     = win;
          prio_nxt      = ~win;
          fll_addr_nxt  = win ? s_addr_i[2*ADDR_W-1:ADDR_W]  : s_addr_i[ADDR_W-1:0];
          fll_wdata_nxt = win ? s_wdata_i[2*DATA_W-1:DATA_W] : s_wdata_i[DATA_W-1:0];
          fll_web_nxt   = s_web_i[win];
          fll_req_nxt   = 1'b1;
          busy_nxt      = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // A real ack beats a timeout landing on the same edge
        if (fll_ack_i) begin
          fll_req_nxt = 1'b0;
          s_rdata_nxt = fll_rdata_i;
          s_err_nxt   = 1'b0;
          s_ack_nxt   = grant_o ? 2'b10 : 2'b01;
          state_nxt   = RESP;
        end else if (cnt == CNT_LAST) begin
          fll_req_nxt = 1'b0;
          s_rdata_nxt = '0;
          s_err_nxt   = 1'b1;
          s_ack_nxt   = grant_o ? 2'b10 : 2'b01;
          state_nxt   = RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RESP: begin
        // single-cycle ack pulse; requests are re-evaluated back in IDLE
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        fll_req_nxt = 1'b0;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      prio        <= 1'b0;
      s_ack_o     <= 2'b00;
      s_rdata_o   <= '0;
      s_err_o     <= 1'b0;
      fll_req_o   <= 1'b0;
      fll_addr_o  <= '0;
      fll_wdata_o <= '0;
      fll_web_o   <= 1'b1;
      busy_o      <= 1'b0;
      grant_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      prio        <= prio_nxt;
      s_ack_o     <= s_ack_nxt;
      s_rdata_o   <= s_rdata_nxt;
      s_err_o     <= s_err_nxt;
      fll_req_o   <= fll_req_nxt;
      fll_addr_o  <= fll_addr_nxt;
      fll_wdata_o <= fll_wdata_nxt;
      fll_web_o   <= fll_web_nxt;
      busy_o      <= busy_nxt;
      grant_o     <= grant_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fll_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fll_cfg_arbiter
// Description : Bench for fll_cfg_arbiter. Inputs are driven each negedge,
//               a transaction-level model predicts every output, and outputs
//               are compared 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fll_cfg_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int T      = 8;
  localparam int AW2    = 2 * ADDR_W;
  localparam int DW2    = 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        s_req_i;
  logic [AW2-1:0]    s_addr_i;
  logic [DW2-1:0]    s_wdata_i;
  logic [1:0]        s_web_i;
  logic [1:0]        s_ack_o;
  logic [DATA_W-1:0] s_rdata_o;
  logic              s_err_o;
  logic              fll_req_o;
  logic [ADDR_W-1:0] fll_addr_o;
  logic [DATA_W-1:0] fll_wdata_o;
  logic              fll_web_o;
  logic              fll_ack_i;
  logic [DATA_W-1:0] fll_rdata_i;
  logic              busy_o;
  logic              grant_o;

  fll_cfg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_web_i(s_web_i),
    .s_ack_o(s_ack_o), .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
    .fll_req_o(fll_req_o), .fll_addr_o(fll_addr_o), .fll_wdata_o(fll_wdata_o),
    .fll_web_o(fll_web_o), .fll_ack_i(fll_ack_i), .fll_rdata_i(fll_rdata_i),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction started at edge N with ack latency
  // L (0 = FLL never answers) completes at edge C = N+L, or N+T on timeout.
  // fll_req is high after edges N..C-1, busy after N..C, s_ack only after C.
  int                e_cnt;
  bit                m_active;
  int                m_N, m_C, m_L;
  bit                m_g, m_prio;
  logic              x_req, x_busy, x_err, x_grant, x_web;
  logic [1:0]        x_ack;
  logic [DATA_W-1:0] x_rdata, x_wdata;
  logic [ADDR_W-1:0] x_addr;

  task automatic model_reset();
    m_active = 0; m_prio = 0; m_g = 0;
    x_req = 0; x_busy = 0; x_err = 0; x_grant = 0; x_web = 1;
    x_ack = 0; x_rdata = 0; x_wdata = 0; x_addr = 0;
  endtask

  task automatic check_outputs();
    check("busy",    64'(busy_o),    64'(x_busy));
    check("fll_req", 64'(fll_req_o), 64'(x_req));
    check("s_ack",   64'(s_ack_o),   64'(x_ack));
    check("grant",   64'(grant_o),   64'(x_grant));
    check("s_err",   64'(s_err_o),   64'(x_err));
    check("s_rdata", 64'(s_rdata_o), 64'(x_rdata));
    if (x_req) begin
      check("fll_addr",  64'(fll_addr_o),  64'(x_addr));
      check("fll_wdata", 64'(fll_wdata_o), 64'(x_wdata));
      check("fll_web",   64'(fll_web_o),   64'(x_web));
    end
  endtask

  // One clock: drive at negedge, advance the model, compare after the edge.
  // L: -1 random latency, 0 never ack, >0 ack on the L-th edge after start.
  task automatic cycle(input logic [1:0] req, input logic [AW2-1:0] a,
                       input logic [DW2-1:0] wd, input logic [1:0] web,
                       input logic [DATA_W-1:0] rd, input int L, input bit spur);
    logic ack;
    s_req_i = req; s_addr_i = a; s_wdata_i = wd; s_web_i = web; fll_rdata_i = rd;
    e_cnt++;
    ack = 1'b0;
    if (m_active && e_cnt <= m_C) ack = (m_L != 0) && (e_cnt == m_N + m_L);
    else if (spur) ack = 1'($urandom_range(0, 1));
    fll_ack_i = ack;

    if (m_active && e_cnt == m_C) begin
      x_req   = 0;
      x_ack   = m_g ? 2'b10 : 2'b01;
      x_err   = (m_L == 0);
      x_rdata = (m_L != 0) ? rd : '0;
    end else if (m_active && e_cnt == m_C + 1) begin
      x_ack = 0; x_busy = 0; m_active = 0;
    end else if (!m_active && req != 2'b00) begin
      m_g      = (req == 2'b11) ? m_prio : req[1];
      m_prio   = ~m_g;
      m_active = 1;
      m_N      = e_cnt;
      if (L >= 0) m_L = L;
      else m_L = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, T));
      m_C      = (m_L != 0) ? m_N + m_L : m_N + T;
      x_req    = 1; x_busy = 1; x_grant = m_g;
      x_addr   = m_g ? a[AW2-1:ADDR_W]  : a[ADDR_W-1:0];
      x_wdata  = m_g ? wd[DW2-1:DATA_W] : wd[DATA_W-1:0];
      x_web    = web[m_g];
    end

    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drain(input logic [DATA_W-1:0] rd);
    while (m_active)
      cycle(2'b00, AW2'($urandom), {$urandom, $urandom}, 2'($urandom), rd, -1, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; fll_ack_i = 1'b0; s_req_i = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check("rst_fll_addr",  64'(fll_addr_o),  64'(0));
    check("rst_fll_wdata", 64'(fll_wdata_o), 64'(0));
    check("rst_fll_web",   64'(fll_web_o),   64'(1));
    rst = 1'b0;
  endtask

  initial begin
    e_cnt = 0;
    s_addr_i = '0; s_wdata_i = '0; s_web_i = 2'b11; fll_rdata_i = '0;
    apply_reset();

    // port 0 write addr 2, FLL answers after 5 cycles
    cycle(2'b01, {2'd0, 2'd2}, {32'h0, 32'hC000_1234}, 2'b10, 32'h0, 5, 0);
    drain(32'h5555_5555);

    // port 1 read returning 0xAB
    cycle(2'b10, {2'd1, 2'd0}, {$urandom, $urandom}, 2'b11, 32'h0, 3, 0);
    drain(32'h0000_00AB);

    // never acked -> timeout; then ack exactly on the timeout edge
    cycle(2'b01, AW2'($urandom), {$urandom, $urandom}, 2'b11, 32'h1, 0, 0);
    drain(32'hDEAD_BEEF);
    cycle(2'b10, AW2'($urandom), {$urandom, $urandom}, 2'b00, 32'h1, T, 0);
    drain(32'h1234_5678);

    // both ports requesting continuously from reset alternate 0,1,0,1
    apply_reset();
    repeat (24)
      cycle(2'b11, AW2'($urandom), {$urandom, $urandom}, 2'($urandom), $urandom,
            int'($urandom_range(1, 3)), 0);
    drain($urandom);

    // reset during WAIT_ACK drops fll_req at once with no ack
    cycle(2'b01, AW2'($urandom), {$urandom, $urandom}, 2'b00, 32'h0, 0, 0);
    cycle(2'b00, AW2'($urandom), {$urandom, $urandom}, 2'b00, 32'h0, -1, 0);
    cycle(2'b00, AW2'($urandom), {$urandom, $urandom}, 2'b00, 32'h0, -1, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_fll_req", 64'(fll_req_o), 64'(0));
    check("midrst_s_ack",   64'(s_ack_o),   64'(0));
    check("midrst_busy",    64'(busy_o),    64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // late FLL acks after release are ignored, then port 1 is served
    repeat (3) cycle(2'b00, AW2'($urandom), {$urandom, $urandom}, 2'b11, $urandom, -1, 1);
    cycle(2'b10, AW2'($urandom), {$urandom, $urandom}, 2'b01, $urandom, 2, 0);
    drain($urandom);

    // spurious acks while idle
    repeat (6) cycle(2'b00, AW2'($urandom), {$urandom, $urandom}, 2'b11, $urandom, -1, 1);

    // randomized traffic
    repeat (500)
      cycle(2'($urandom), AW2'($urandom), {$urandom, $urandom}, 2'($urandom), $urandom, -1, 1);
    drain($urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fll_cfg_arbiter.md
FLL_CFG_ARBITER -- requirements
Module: fll_cfg_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 2, FLL config address width.
REQ-002 The block SHALL expose parameter DATA_W, default 32, FLL config data width.
REQ-003 The block SHALL expose parameter TIMEOUT_CYCLES, default 1024, maximum cycles waiting for FLL ack (legal range 2..65535).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  sole clock; rst_i  in  1  asynchronous active-high reset.
REQ-005 s_req_i  in  2  per-requester access request (index 0 = boot/debug, 1 = SoC register port).
REQ-006 s_addr_i  in  2xADDR_W  per-requester address; s_wdata_i  in  2xDATA_W  write data; s_web_i  in  2  write enable, active low.
REQ-007 s_ack_o  out  2  one-cycle completion pulse per requester; s_rdata_o  out  DATA_W  shared read data, valid with s_ack_o; s_err_o  out  1  timeout flag, valid with s_ack_o.
REQ-008 fll_req_o  out  1; fll_addr_o  out  ADDR_W; fll_wdata_o  out  DATA_W; fll_web_o  out  1; fll_ack_i  in  1; fll_rdata_i  in  DATA_W  FLL config bus master side.
REQ-009 busy_o  out  1  transaction in flight; grant_o  out  1  index of current/last granted requester.

Function
REQ-010 FSM states SHALL be IDLE, WAIT_ACK, RESP; all outputs registered.
REQ-011 IDLE: if any s_req_i bit high at a clock edge, grant latched, requester's addr/wdata/web captured, fll_req_o high from next cycle, state -> WAIT_ACK.
REQ-012 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; after reset port 0 has priority.
REQ-013 fll_addr_o/fll_wdata_o/fll_web_o SHALL hold captured values stable while fll_req_o is high.
REQ-014 WAIT_ACK: edge sampling fll_ack_i=1 -> fll_req_o low, fll_rdata_i captured into s_rdata_o, s_ack_o[grant]=1, s_err_o=0 next cycle, state -> RESP.
REQ-015 WAIT_ACK timeout counter SHALL start at 0 on entry, increment per cycle; at count TIMEOUT_CYCLES-1 with fll_ack_i=0 -> fll_req_o low, s_rdata_o=0, s_err_o=1, s_ack_o[grant]=1 next cycle, state -> RESP.
REQ-016 fll_ack_i=1 on the same edge as timeout SHALL win: normal completion, s_err_o=0.
REQ-017 RESP SHALL last exactly one cycle (s_ack_o pulse), then -> IDLE; s_req_i ignored during WAIT_ACK and RESP.
REQ-018 Requester holding s_req_i high after its ack SHALL be treated as a new request in IDLE (back-to-back allowed; arbitration re-evaluated each time).
REQ-019 Requester dropping s_req_i during WAIT_ACK SHALL NOT abort the transaction; ack still pulses.
REQ-020 fll_ack_i high in IDLE or RESP SHALL be ignored, no state change.
REQ-021 Latency: s_req_i sampled at edge N -> fll_req_o high cycle N+1; fll_ack_i sampled at edge K -> s_ack_o high cycle K+1; minimum 3 cycles per transaction.
REQ-022 busy_o SHALL be high in WAIT_ACK and RESP, low in IDLE.
REQ-023 s_rdata_o and s_err_o SHALL hold last values until next completion.

Reset
REQ-024 rst_i high SHALL asynchronously force state IDLE, fll_req_o=0, s_ack_o=0, s_err_o=0, s_rdata_o=0, fll_addr_o=0, fll_wdata_o=0, fll_web_o=1, busy_o=0, grant_o=0, counter=0, round-robin pointer favouring port 0.
REQ-025 rst_i asserted mid-transaction SHALL drop fll_req_o immediately with no ack issued; FLL late ack after reset release ignored per REQ-020.

Verification
REQ-026 Port 0 write addr=2 wdata=0xC000_1234, FLL acks after 5 cycles -> fll_req_o high 5 cycles, fll_web_o=0, s_ack_o=2'b01 one cycle, s_err_o=0.
REQ-027 Both ports request every cycle from reset -> grants alternate 0,1,0,1; each port gets one ack per two transactions.
REQ-028 Port 1 read, fll_rdata_i=0x0000_00AB at ack -> s_ack_o=2'b10, s_rdata_o=0xAB, grant_o=1.
REQ-029 TIMEOUT_CYCLES=8, FLL never acks -> fll_req_o high exactly 8 cycles, then s_ack_o pulse with s_err_o=1, s_rdata_o=0; ack at cycle 8 instead -> s_err_o=0.
REQ-030 rst_i pulsed during WAIT_ACK -> fll_req_o low same cycle, no s_ack_o; following request from port 1 only served normally.
REQ-031 Spurious fll_ack_i in IDLE -> no s_ack_o, busy_o stays 0.
